id_control: RTL and testbench

ID_CONTROL -- requirements
Module: id_control

---
 rtl/id_control_pkg.sv | 100 ++++++++++
 rtl/imm_gen.sv | 22 ++
 rtl/id_control.sv | 167 ++++++++++++++++
 tb/tb_id_control.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/id_control_pkg.sv
// rtl/id_control_pkg.sv - RV32I decode constants shared by the ID stage
// Purpose: opcodes, funct3/funct7 values, ALU_op codes, ALU_source_sel codes,
//          the pipeline control bundle and the funct3->ALU_op helper.
// Ports:   none (package).
package id_control_pkg;

  // Major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // ALU funct3
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Load/store/jalr funct3
  localparam logic [2:0] F3_LB   = 3'b000;
  localparam logic [2:0] F3_LH   = 3'b001;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_LBU  = 3'b100;
  localparam logic [2:0] F3_LHU  = 3'b101;
  localparam logic [2:0] F3_SB   = 3'b000;
  localparam logic [2:0] F3_SH   = 3'b001;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;

  // funct7
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // ALU_op codes
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  // ALU_source_sel codes
  localparam logic [1:0] SEL_RS1_RS2  = 2'b00;
  localparam logic [1:0] SEL_RS1_IMM  = 2'b01;
  localparam logic [1:0] SEL_PC_IMM   = 2'b10;
  localparam logic [1:0] SEL_ZERO_IMM = 2'b11;

  typedef struct packed {
    logic branch;
    logic mem_wr;
    logic mem_rd;
    logic reg_wr;
    logic mem_to_reg;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE   = 5'b00000;
  localparam ctrl_t CTRL_ALU    = 5'b00010;
  localparam ctrl_t CTRL_LOAD   = 5'b00111;
  localparam ctrl_t CTRL_STORE  = 5'b01000;
  localparam ctrl_t CTRL_BRANCH = 5'b10000;
  localparam ctrl_t CTRL_JUMP   = 5'b10010;

  // alt = funct7[5]; only meaningful for ADD/SUB and SRL/SRA
  function automatic logic [3:0] alu_op_decode(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      op = ALU_OR;
      default:    op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - RV32I immediate extraction
// Purpose: sign-extended I/S/B/J immediates and the U immediate.
// Ports:   i_instr  in  [31:7]  instruction word (opcode bits carry no immediate)
//          o_imm_i/o_imm_s/o_imm_b/o_imm_u/o_imm_j  out 32  immediates
module imm_gen (
  input  logic [31:7] i_instr,
  output logic [31:0] o_imm_i,
  output logic [31:0] o_imm_s,
  output logic [31:0] o_imm_b,
  output logic [31:0] o_imm_u,
  output logic [31:0] o_imm_j
);

  assign o_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign o_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign o_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                    i_instr[11:8], 1'b0};
  assign o_imm_u = {i_instr[31:12], 12'b0};
  assign o_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                    i_instr[30:21], 1'b0};

endmodule

// File: rtl/id_control.sv
// rtl/id_control.sv - RV32I instruction decode / control generation
// Purpose: zero-latency decode of the fetched word into ALU, memory, branch and
//          register-file controls plus immediates and register addresses.
// Ports:   clk, rst (sync, active-high), IF_Instruction[31:0], IF_PC[31:0],
//          Pipe_stall; Immediate_1/Immediate_2[31:0], ALU_source_sel[1:0],
//          ALU_op[3:0], Branch_en, Mem_wr_en, Mem_rd_en, RegFile_wr_en,
//          MemToReg, Funct3[2:0], Rd_address/Rs1_address/Rs2_address[4:0]
module id_control
  import id_control_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IF_Instruction,
  input  logic [31:0] IF_PC,
  input  logic        Pipe_stall,
  output logic [31:0] Immediate_1,
  output logic [31:0] Immediate_2,
  output logic [1:0]  ALU_source_sel,
  output logic [3:0]  ALU_op,
  output logic        Branch_en,
  output logic        Mem_wr_en,
  output logic        Mem_rd_en,
  output logic        RegFile_wr_en,
  output logic        MemToReg,
  output logic [2:0]  Funct3,
  output logic [4:0]  Rd_address,
  output logic [4:0]  Rs1_address,
  output logic [4:0]  Rs2_address
);

  logic        r_ready;
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  ctrl_t       w_ctrl;
  logic [3:0]  w_alu_op;
  logic [1:0]  w_sel;
  logic [31:0] w_imm1, w_imm2;
  logic        w_bubble;

  // Goes high on the first edge with rst low; gates controls until then
  always_ff @(posedge clk) begin
    if (rst) r_ready <= 1'b0;
    else     r_ready <= 1'b1;
  end

  assign w_opcode = IF_Instruction[6:0];
  assign w_funct3 = IF_Instruction[14:12];
  assign w_funct7 = IF_Instruction[31:25];

  imm_gen u_imm_gen (
    .i_instr (IF_Instruction[31:7]),
    .o_imm_i (w_imm_i),
    .o_imm_s (w_imm_s),
    .o_imm_b (w_imm_b),
    .o_imm_u (w_imm_u),
    .o_imm_j (w_imm_j)
  );

  // Anything not explicitly matched falls through as a NOP
  always_comb begin
    w_ctrl   = CTRL_NONE;
    w_alu_op = ALU_ADD;
    w_sel    = SEL_RS1_RS2;
    w_imm1   = '0;
    w_imm2   = '0;
    case (w_opcode)
      OPC_OP: begin
        if (w_funct7 == F7_BASE ||
            (w_funct7 == F7_ALT && (w_funct3 == F3_ADD_SUB || w_funct3 == F3_SRL_SRA))) begin
          w_ctrl   = CTRL_ALU;
          w_alu_op = alu_op_decode(w_funct3, w_funct7[5]);
        end
      end
      OPC_OP_IMM: begin
        if (w_funct3 == F3_SLL || w_funct3 == F3_SRL_SRA) begin
          // Shift immediates carry funct7 in the upper bits; only shamt is the operand
          if (w_funct7 == F7_BASE || (w_funct3 == F3_SRL_SRA && w_funct7 == F7_ALT)) begin
            w_ctrl   = CTRL_ALU;
            w_sel    = SEL_RS1_IMM;
            w_alu_op = alu_op_decode(w_funct3, w_funct7[5]);
            w_imm2   = {27'b0, IF_Instruction[24:20]};
          end
        end else begin
          w_ctrl   = CTRL_ALU;
          w_sel    = SEL_RS1_IMM;
          w_alu_op = alu_op_decode(w_funct3, 1'b0);
          w_imm2   = w_imm_i;
        end
      end
      OPC_LOAD: begin
        if (w_funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU}) begin
          w_ctrl = CTRL_LOAD;
          w_sel  = SEL_RS1_IMM;
          w_imm2 = w_imm_i;
        end
      end
      OPC_STORE: begin
        if (w_funct3 inside {F3_SB, F3_SH, F3_SW}) begin
          w_ctrl = CTRL_STORE;
          w_sel  = SEL_RS1_IMM;
          w_imm2 = w_imm_s;
        end
      end
      OPC_BRANCH: begin
        case (w_funct3)
          F3_BEQ, F3_BNE: begin
            w_ctrl = CTRL_BRANCH; w_alu_op = ALU_SUB; w_imm1 = IF_PC + w_imm_b;
          end
          F3_BLT, F3_BGE: begin
            w_ctrl = CTRL_BRANCH; w_alu_op = ALU_SLT; w_imm1 = IF_PC + w_imm_b;
          end
          F3_BLTU, F3_BGEU: begin
            w_ctrl = CTRL_BRANCH; w_alu_op = ALU_SLTU; w_imm1 = IF_PC + w_imm_b;
          end
          default: ;
        endcase
      end
      // Jumps compute the link address PC+4 in the ALU
      OPC_JAL: begin
        w_ctrl = CTRL_JUMP;
        w_sel  = SEL_PC_IMM;
        w_imm2 = 32'd4;
        w_imm1 = IF_PC + w_imm_j;
      end
      OPC_JALR: begin
        if (w_funct3 == F3_JALR) begin
          w_ctrl = CTRL_JUMP;
          w_sel  = SEL_PC_IMM;
          w_imm2 = 32'd4;
          w_imm1 = w_imm_i;
        end
      end
      OPC_LUI: begin
        w_ctrl = CTRL_ALU;
        w_sel  = SEL_ZERO_IMM;
        w_imm2 = w_imm_u;
      end
      OPC_AUIPC: begin
        w_ctrl = CTRL_ALU;
        w_sel  = SEL_PC_IMM;
        w_imm2 = w_imm_u;
      end
      default: ;
    endcase
  end

  // Bubble kills side effects only; immediates and fields stay decoded
  assign w_bubble = Pipe_stall | ~r_ready;

  assign Branch_en      = w_bubble ? 1'b0 : w_ctrl.branch;
  assign Mem_wr_en      = w_bubble ? 1'b0 : w_ctrl.mem_wr;
  assign Mem_rd_en      = w_bubble ? 1'b0 : w_ctrl.mem_rd;
  assign RegFile_wr_en  = w_bubble ? 1'b0 : w_ctrl.reg_wr;
  assign MemToReg       = w_bubble ? 1'b0 : w_ctrl.mem_to_reg;
  assign ALU_op         = w_bubble ? ALU_ADD : w_alu_op;
  assign ALU_source_sel = w_bubble ? SEL_RS1_RS2 : w_sel;

  assign Immediate_1 = w_imm1;
  assign Immediate_2 = w_imm2;
  assign Funct3      = w_funct3;
  assign Rd_address  = IF_Instruction[11:7];
  assign Rs1_address = IF_Instruction[19:15];
  assign Rs2_address = IF_Instruction[24:20];

endmodule

// File: tb/tb_id_control.sv
// tb/tb_id_control.sv - scoreboard bench for id_control
module tb_id_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] IF_Instruction = '0;
  logic [31:0] IF_PC = '0;
  logic        Pipe_stall = 1'b0;
  logic [31:0] Immediate_1, Immediate_2;
  logic [1:0]  ALU_source_sel;
  logic [3:0]  ALU_op;
  logic        Branch_en, Mem_wr_en, Mem_rd_en, RegFile_wr_en, MemToReg;
  logic [2:0]  Funct3;
  logic [4:0]  Rd_address, Rs1_address, Rs2_address;

  always #5 clk = ~clk;

  id_control dut (
    .clk(clk), .rst(rst), .IF_Instruction(IF_Instruction), .IF_PC(IF_PC),
    .Pipe_stall(Pipe_stall), .Immediate_1(Immediate_1), .Immediate_2(Immediate_2),
    .ALU_source_sel(ALU_source_sel), .ALU_op(ALU_op), .Branch_en(Branch_en),
    .Mem_wr_en(Mem_wr_en), .Mem_rd_en(Mem_rd_en), .RegFile_wr_en(RegFile_wr_en),
    .MemToReg(MemToReg), .Funct3(Funct3), .Rd_address(Rd_address),
    .Rs1_address(Rs1_address), .Rs2_address(Rs2_address)
  );

  typedef struct packed {
    logic [31:0] imm1;
    logic [31:0] imm2;
    logic [1:0]  sel;
    logic [3:0]  op;
    logic [4:0]  ctrl;   // {branch, mem_wr, mem_rd, reg_wr, mem_to_reg}
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   vec   = 0;
  bit   done  = 0;

  // ALU code for each funct3 with funct7[5]=0; the alternate form is the next code
  localparam int BASE_OP [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
  localparam logic [6:0] OPCS [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                                      7'h6F, 7'h67, 7'h37, 7'h17};

  function automatic exp_t mk(input logic [31:0] imm1, imm2, input logic [1:0] sel,
                              input logic [3:0] op, input logic [4:0] ctrl,
                              input logic [2:0] f3, input logic [4:0] rd, rs1, rs2);
    exp_t e;
    e.imm1 = imm1; e.imm2 = imm2; e.sel = sel; e.op = op; e.ctrl = ctrl;
    e.f3 = f3; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
    return e;
  endfunction

  // Reference decode built from the ISA tables with integer arithmetic
  function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc, input bit bubble);
    exp_t e;
    int ii, is, ib, ij;
    logic [2:0] f3;
    logic [6:0] f7;
    bit alt;
    f3 = w[14:12];
    f7 = w[31:25];
    alt = (f7 == 7'h20);
    e = '0;
    e.f3 = f3; e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
    ii = int'(w[31:20]) - (w[31] ? 4096 : 0);
    is = int'({w[31:25], w[11:7]}) - (w[31] ? 4096 : 0);
    ib = int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2 - (w[31] ? 4096 : 0);
    ij = int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2 - (w[31] ? 1048576 : 0);
    case (w[6:0])
      7'h33: if (f7 == 7'h00 || (alt && (f3 == 3'd0 || f3 == 3'd5))) begin
        e.op = 4'(BASE_OP[f3] + int'(alt)); e.ctrl = 5'b00010;
      end
      7'h13: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          if (f7 == 7'h00 || (f3 == 3'd5 && alt)) begin
            e.sel = 2'd1; e.op = 4'(BASE_OP[f3] + int'(alt)); e.ctrl = 5'b00010;
            e.imm2 = 32'(int'(w[24:20]));
          end
        end else begin
          e.sel = 2'd1; e.op = 4'(BASE_OP[f3]); e.ctrl = 5'b00010; e.imm2 = 32'(ii);
        end
      end
      7'h03: if (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin
        e.sel = 2'd1; e.ctrl = 5'b00111; e.imm2 = 32'(ii);
      end
      7'h23: if (f3 <= 3'd2) begin
        e.sel = 2'd1; e.ctrl = 5'b01000; e.imm2 = 32'(is);
      end
      7'h63: if (f3 != 3'd2 && f3 != 3'd3) begin
        e.op = (f3 < 3'd2) ? 4'd1 : (f3 < 3'd6) ? 4'd3 : 4'd4;
        e.ctrl = 5'b10000; e.imm1 = pc + 32'(ib);
      end
      7'h6F: begin
        e.sel = 2'd2; e.imm2 = 32'd4; e.ctrl = 5'b10010; e.imm1 = pc + 32'(ij);
      end
      7'h67: if (f3 == 3'd0) begin
        e.sel = 2'd2; e.imm2 = 32'd4; e.ctrl = 5'b10010; e.imm1 = 32'(ii);
      end
      7'h37: begin e.sel = 2'd3; e.imm2 = w & 32'hFFFFF000; e.ctrl = 5'b00010; end
      7'h17: begin e.sel = 2'd2; e.imm2 = w & 32'hFFFFF000; e.ctrl = 5'b00010; end
      default: ;
    endcase
    if (bubble) begin e.ctrl = '0; e.op = '0; e.sel = '0; end
    return e;
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] o, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3);
    return {o[12], o[10:5], rs2, rs1, f3, o[4:1], o[11], 7'h63};
  endfunction

  // Drive one vector just after the edge; expected ready is what rst was at that edge
  task automatic drive(input logic [31:0] w, pc, input logic stall, rstv,
                       input bit use_model, input exp_t fixed);
    bit rdy;
    @(posedge clk);
    rdy = !rst;
    #1;
    IF_Instruction = w;
    IF_PC = pc;
    Pipe_stall = stall;
    rst = rstv;
    sb.push_back(use_model ? model(w, pc, stall | !rdy) : fixed);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %h required %h", name, vec, act, req);
    end
  endtask

  // Monitor: outputs are combinational, so sample mid-cycle and pop one entry
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("ctrl", 32'({Branch_en, Mem_wr_en, Mem_rd_en, RegFile_wr_en, MemToReg}), 32'(e.ctrl));
        chk("alu_op", 32'(ALU_op), 32'(e.op));
        chk("src_sel", 32'(ALU_source_sel), 32'(e.sel));
        chk("imm1", Immediate_1, e.imm1);
        chk("imm2", Immediate_2, e.imm2);
        chk("fields", 32'({Funct3, Rd_address, Rs1_address, Rs2_address}),
            32'({e.f3, e.rd, e.rs1, e.rs2}));
        vec++;
      end
    end
  end

  initial begin
    logic [31:0] w, pc, add_w, lw_w;
    logic        stall, rstv;
    int          pick;

    add_w = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd30);
    lw_w  = enc_i(12'hFFC, 5'd3, 3'd2, 5'd5, 7'h03);

    // Reset held with a valid ADD, then released
    drive(add_w, 32'h0, 1'b0, 1'b1, 0, mk(0, 0, 2'd0, 4'd0, 5'b00000, 3'd0, 5'd30, 5'd1, 5'd2));
    drive(add_w, 32'h0, 1'b0, 1'b0, 0, mk(0, 0, 2'd0, 4'd0, 5'b00000, 3'd0, 5'd30, 5'd1, 5'd2));
    drive(add_w, 32'h0, 1'b0, 1'b0, 0, mk(0, 0, 2'd0, 4'd0, 5'b00010, 3'd0, 5'd30, 5'd1, 5'd2));
    // SUB x19,x5,x6 ; SLL x15,x19,x30
    drive(enc_r(7'h20, 5'd6, 5'd5, 3'd0, 5'd19), 32'h0, 1'b0, 1'b0, 0,
          mk(0, 0, 2'd0, 4'd1, 5'b00010, 3'd0, 5'd19, 5'd5, 5'd6));
    drive(enc_r(7'h00, 5'd30, 5'd19, 3'd1, 5'd15), 32'h0, 1'b0, 1'b0, 0,
          mk(0, 0, 2'd0, 4'd2, 5'b00010, 3'd1, 5'd15, 5'd19, 5'd30));
    // SLLI x2,x22,18
    drive(enc_i(12'd18, 5'd22, 3'd1, 5'd2, 7'h13), 32'h0, 1'b0, 1'b0, 0,
          mk(0, 32'd18, 2'd1, 4'd2, 5'b00010, 3'd1, 5'd2, 5'd22, 5'd18));
    // BEQ x1,x2,-8 at PC 69
    drive(enc_b(13'h1FF8, 5'd2, 5'd1, 3'd0), 32'd69, 1'b0, 1'b0, 0,
          mk(32'd61, 0, 2'd0, 4'd1, 5'b10000, 3'd0, 5'd25, 5'd1, 5'd2));
    // LW x5,-4(x3), then the same word stalled
    drive(lw_w, 32'h0, 1'b0, 1'b0, 0,
          mk(0, 32'hFFFFFFFC, 2'd1, 4'd0, 5'b00111, 3'd2, 5'd5, 5'd3, 5'd28));
    drive(lw_w, 32'h0, 1'b1, 1'b0, 0,
          mk(0, 32'hFFFFFFFC, 2'd0, 4'd0, 5'b00000, 3'd2, 5'd5, 5'd3, 5'd28));
    // All-zero word is a NOP
    drive(32'h0, 32'h1234, 1'b0, 1'b0, 0, mk(0, 0, 2'd0, 4'd0, 5'b00000, 3'd0, 5'd0, 5'd0, 5'd0));

    // Randomised phase: mostly legal opcodes, random fields, occasional stall/reset
    for (int k = 0; k < 600; k++) begin
      w = $urandom;
      pick = int'($urandom_range(0, 9));
      if (pick < 9) w[6:0] = OPCS[pick];
      if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      pc = ($urandom_range(0, 3) == 0) ? (32'hFFFFFF00 | 32'($urandom_range(0, 255))) : $urandom;
      stall = ($urandom_range(0, 7) == 0);
      rstv  = ($urandom_range(0, 24) == 0);
      drive(w, pc, stall, rstv, 1, '0);
    end

    repeat (3) @(negedge clk);
    chk("drain", 32'(sb.size()), 32'd0);
    done = 1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL timeout: got no completion required completion");
      $fatal(1);
    end
  end

endmodule
